tcam_match_array: RTL and testbench

- Storage and search front end of the TCAM. Holds ENTRIES ternary entries, each with a value, a care mask and a valid bit.
- Compares a search key against all entries in parallel and presents a registered one-hot-or-multi-hot match vector.
- The match vector feeds the 16-to-4 priority encoder stage directly. Higher index means higher priority downstream.
- Also tracks entry occupancy for software and debug.

---
 rtl/tcam_pkg.sv | 9 +
 rtl/tcam_match_array_if.sv | 29 ++
 rtl/tcam_entry.sv | 40 ++++
 rtl/tcam_match_array.sv | 74 +++++++
 tb/tb_tcam_match_array.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tcam_pkg.sv
// Purpose: shared TCAM sizing constants, also used by the downstream priority encoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tcam_pkg;
  localparam int ENTRIES = 16;
  localparam int WIDTH   = 8;
  localparam int ADDR_W  = $clog2(ENTRIES);
  localparam int CNT_W   = $clog2(ENTRIES + 1);
endpackage

// File: rtl/tcam_match_array_if.sv
// Purpose: write, clear and search request bundle plus the registered search result.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take every result.
interface tcam_match_array_if;
  import tcam_pkg::*;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   wr_care;
  logic               wr_valid;
  logic               clear_all;
  logic               srch_en;
  logic [WIDTH-1:0]   srch_key;
  logic               match_valid;
  logic [ENTRIES-1:0] match_lines;
  logic               any_hit;
  logic [CNT_W-1:0]   entry_count;

  modport master (
    output wr_en, wr_addr, wr_data, wr_care, wr_valid, clear_all, srch_en, srch_key,
    input  match_valid, match_lines, any_hit, entry_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_care, wr_valid, clear_all, srch_en, srch_key,
    output match_valid, match_lines, any_hit, entry_count
  );
endinterface

// File: rtl/tcam_entry.sv
// Purpose: one ternary row (value, care mask, valid) with its combinational match bit.
// Latency: match is combinational on the stored contents; writes land at the clock edge.
// Backpressure: none.
module tcam_entry
  import tcam_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] srch_key,
  output logic             valid,
  output logic             match
);
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] care;

  // Row storage; clear only drops the valid bit so value/care survive a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      care  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (we) begin
      value <= wr_data;
      care  <= wr_care;
      valid <= wr_valid;
    end
  end

  // Cared-about bits must agree; an invalid row never matches.
  always_comb begin
    match = valid && (((srch_key ^ value) & care) == '0);
  end
endmodule

// File: rtl/tcam_match_array.sv
// Purpose: TCAM row array with write decode, clear_all, registered match vector and occupancy count.
// Latency: search launched at edge N is visible during cycle N+1; writes seen by searches from edge N+1.
// Backpressure: none; one search per cycle accepted, every result must be consumed.
module tcam_match_array
  import tcam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  tcam_match_array_if.slave bus
);
  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] match_vec;
  logic [ENTRIES-1:0] row_we;
  logic               wr_ok;
  logic               old_valid;

  // Decode the write; clear_all suppresses it and out-of-range rows are ignored.
  always_comb begin
    wr_ok     = bus.wr_en && !bus.clear_all && (32'(bus.wr_addr) < ENTRIES);
    old_valid = 1'b0;
    row_we    = '0;
    if (wr_ok) begin
      old_valid = valid_vec[bus.wr_addr];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      row_we[i] = wr_ok && (bus.wr_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_row
    tcam_entry u_entry (
      .clk      (clk),
      .rst      (rst),
      .we       (row_we[g]),
      .clr      (bus.clear_all),
      .wr_data  (bus.wr_data),
      .wr_care  (bus.wr_care),
      .wr_valid (bus.wr_valid),
      .srch_key (bus.srch_key),
      .valid    (valid_vec[g]),
      .match    (match_vec[g])
    );
  end

  // Capture the match vector from pre-write contents; hold it when no search is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.match_valid <= 1'b0;
      bus.match_lines <= '0;
      bus.any_hit     <= 1'b0;
    end else if (bus.srch_en) begin
      bus.match_valid <= 1'b1;
      bus.match_lines <= match_vec;
      bus.any_hit     <= |match_vec;
    end else begin
      bus.match_valid <= 1'b0;
    end
  end

  // Occupancy moves only on valid-bit transitions; clear_all zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.entry_count <= '0;
    end else if (bus.clear_all) begin
      bus.entry_count <= '0;
    end else if (wr_ok) begin
      if (bus.wr_valid && !old_valid) begin
        bus.entry_count <= bus.entry_count + CNT_W'(1);
      end else if (!bus.wr_valid && old_valid) begin
        bus.entry_count <= bus.entry_count - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tcam_match_array.sv
// Purpose: directed + randomized check of tcam_match_array against a row-table reference model.
// Latency: model predicts results one cycle after the launching edge.
// Backpressure: none.
module tb_tcam_match_array;
  import tcam_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcam_match_array_if bus ();

  tcam_match_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference table: plain arrays of stored rows.
  logic [WIDTH-1:0]   m_val  [ENTRIES];
  logic [WIDTH-1:0]   m_care [ENTRIES];
  logic               m_vld  [ENTRIES];
  logic               exp_mv;
  logic [ENTRIES-1:0] exp_lines;
  logic               exp_hit;
  int tests = 0;
  int fails = 0;

  function automatic logic [ENTRIES-1:0] ref_match(input logic [WIDTH-1:0] key);
    logic [ENTRIES-1:0] r;
    r = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      r[i] = m_vld[i] && ((key & m_care[i]) == (m_val[i] & m_care[i]));
    end
    return r;
  endfunction

  function automatic int ref_count();
    int n;
    n = 0;
    for (int i = 0; i < ENTRIES; i++) n += int'(m_vld[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_val[i]  = '0;
      m_care[i] = '0;
      m_vld[i]  = 1'b0;
    end
    exp_mv    = 1'b0;
    exp_lines = '0;
    exp_hit   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] data,
                       input logic [WIDTH-1:0] care, input logic vld, input logic clr,
                       input logic se, input logic [WIDTH-1:0] key);
    bus.wr_en     = we;
    bus.wr_addr   = addr;
    bus.wr_data   = data;
    bus.wr_care   = care;
    bus.wr_valid  = vld;
    bus.clear_all = clr;
    bus.srch_en   = se;
    bus.srch_key  = key;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // One clock: predict from pre-edge table, then apply clear/write, then compare.
  task automatic tick();
    @(posedge clk);
    if (bus.srch_en) begin
      exp_lines = ref_match(bus.srch_key);
      exp_hit   = (exp_lines != '0);
      exp_mv    = 1'b1;
    end else begin
      exp_mv = 1'b0;
    end
    if (bus.clear_all) begin
      for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
    end else if (bus.wr_en && int'(bus.wr_addr) < ENTRIES) begin
      m_val[bus.wr_addr]  = bus.wr_data;
      m_care[bus.wr_addr] = bus.wr_care;
      m_vld[bus.wr_addr]  = bus.wr_valid;
    end
    #1;
    check("match_valid", 32'(bus.match_valid), 32'(exp_mv));
    check("match_lines", 32'(bus.match_lines), 32'(exp_lines));
    check("any_hit",     32'(bus.any_hit),     32'(exp_hit));
    check("entry_count", 32'(bus.entry_count), 32'(ref_count()));
  endtask

  initial begin
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] care;
    int               r;

    idle();
    model_reset();
    #1;
    check("rst_mv",    32'(bus.match_valid), 32'd0);
    check("rst_lines", 32'(bus.match_lines), 32'd0);
    check("rst_count", 32'(bus.entry_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty table search.
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h5A);
    tick();
    check("tp1_mv",    32'(bus.match_valid), 32'd1);
    check("tp1_lines", 32'(bus.match_lines), 32'h0000);
    check("tp1_hit",   32'(bus.any_hit),     32'd0);

    // Rows 3 and 12, then two searches.
    drive(1'b1, 4'd3, 8'hA0, 8'hF0, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 4'd12, 8'hA5, 8'hFF, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'hA5);
    tick();
    check("tp2_lines", 32'(bus.match_lines), 32'h1008);
    check("tp2_hit",   32'(bus.any_hit),     32'd1);
    check("tp2_count", 32'(bus.entry_count), 32'd2);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'hA7);
    tick();
    check("tp2_a7", 32'(bus.match_lines), 32'h0008);

    // Wildcard row 7 written on the same edge as a search: read-before-write.
    drive(1'b1, 4'd7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33);
    tick();
    check("tp3_rbw_bit7", 32'(bus.match_lines[7]), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h33);
    tick();
    check("tp3_bit7",  32'(bus.match_lines[7]), 32'd1);
    check("tp3_count", 32'(bus.entry_count),    32'd3);

    // Invalidate row 3, then valid->valid rewrite of row 12.
    drive(1'b1, 4'd3, 8'hA0, 8'hF0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    check("tp4_dec", 32'(bus.entry_count), 32'd2);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'hA0);
    tick();
    check("tp4_bit3", 32'(bus.match_lines[3]), 32'd0);
    drive(1'b1, 4'd12, 8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0, '0);
    tick();
    check("tp4_vv", 32'(bus.entry_count), 32'd2);

    // clear_all beats a same-edge write to row 0.
    drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, '0);
    tick();
    check("tp5_count", 32'(bus.entry_count), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    check("tp5_lines", 32'(bus.match_lines), 32'h0000);

    // Reset during a search discards the in-flight result.
    drive(1'b1, 4'd5, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h11);
    tick();
    check("tp6_pre", 32'(bus.match_lines), 32'h0020);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("tp6_mv",    32'(bus.match_valid), 32'd0);
    check("tp6_lines", 32'(bus.match_lines), 32'd0);
    check("tp6_count", 32'(bus.entry_count), 32'd0);
    @(posedge clk);
    #1;
    check("tp6_hold_mv", 32'(bus.match_valid), 32'd0);
    idle();
    rst = 1'b0;
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'h11);
    tick();
    check("tp6_after", 32'(bus.match_lines), 32'h0000);

    // Randomized traffic against the reference table.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 2));
      care = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : WIDTH'($urandom);
      r = int'($urandom_range(0, ENTRIES - 1));
      key = ($urandom_range(0, 1) == 1) ? (m_val[r] ^ (WIDTH'($urandom) & ~m_care[r]))
                                        : WIDTH'($urandom);
      drive(($urandom_range(0, 1) == 1), ADDR_W'($urandom), WIDTH'($urandom), care,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 3) != 0), key);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
